// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: a small transmit FIFO feeding a frame FSM
// (start, DATA_BITS data LSB first, optional parity, 1 or 2 stop bits).
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_send,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 tx_overflow,
  output logic                 tx_done,
  output logic [2:0]           tx_state
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic              ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (bit_cnt == STOP_LAST);
  // Full is the registered flag, so a push while full is dropped even if a pop happens this cycle.
  assign push      = tx_send && !fifo_full;
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end && last_stop));
  assign tx_state  = state;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      fifo_full   <= (count_next == DEPTH_C);
      fifo_empty  <= (count_next == '0);
      tx_overflow <= tx_send && fifo_full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_reg  <= mem[rd_ptr];
            parity_bit <= (^mem[rd_ptr]) ^ ODD_PAR;
            bit_cnt    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= parity_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse covers the final stop cycle.
          if (last_stop && (baud_cnt == BAUD_PRE))
            tx_done <= 1'b1;
          if (bit_end) begin
            if (!last_stop) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (pop) begin
              shift_reg  <= mem[rd_ptr];
              parity_bit <= (^mem[rd_ptr]) ^ ODD_PAR;
              bit_cnt    <= '0;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, exact per-cycle frame checks,
// a push/overflow vector table, a mid-frame reset and random traffic into a frame decoder.
module tb_uart_tx_param;

  localparam int A_CLKS      = 4;
  localparam int A_FRAME_CYC = 11 * A_CLKS;

  logic       clk;
  logic       rst;
  logic       send_v  [3];
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [6:0] data_c;
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       full_v  [3];
  logic       empty_v [3];
  logic       ovf_v   [3];
  logic       done_v  [3];
  logic [2:0] st_v    [3];

  int         vectors;
  int         miscompares;

  logic [7:0] exp_q [$];
  bit         rx_en;
  bit         rx_active;
  int         rx_cnt;
  int         gap_cnt;
  logic [10:0] rx_bits;
  logic [7:0] rx_b;

  typedef struct {
    logic       send;
    logic [7:0] data;
    logic       accept;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_busy;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs [7];

  uart_tx_param #(.CLKS_PER_BIT(A_CLKS)) dut_a (
    .clk(clk), .rst(rst), .tx_send(send_v[0]), .tx_data(data_a),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_full(full_v[0]), .fifo_empty(empty_v[0]),
    .tx_overflow(ovf_v[0]), .tx_done(done_v[0]), .tx_state(st_v[0])
  );

  uart_tx_param #(.CLKS_PER_BIT(4), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .tx_send(send_v[1]), .tx_data(data_b),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_full(full_v[1]), .fifo_empty(empty_v[1]),
    .tx_overflow(ovf_v[1]), .tx_done(done_v[1]), .tx_state(st_v[1])
  );

  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .tx_send(send_v[2]), .tx_data(data_c),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_full(full_v[2]), .fifo_empty(empty_v[2]),
    .tx_overflow(ovf_v[2]), .tx_done(done_v[2]), .tx_state(st_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input logic s, input logic [7:0] v);
    case (d)
      0:       data_a = v;
      1:       data_b = v;
      default: data_c = v[6:0];
    endcase
    send_v[d] = s;
  endtask

  // Expected line levels come from the frame rules: start 0, data LSB first, parity, stop 1s.
  task automatic checkExactFrame(input int d, input logic [7:0] data, input int nbits,
                                 input int par, input int stops, input int clks);
    logic [15:0] bits;
    int          total;
    int          ones;
    bits    = '1;
    ones    = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bits[1 + i] = data[i];
      ones += int'(data[i]);
    end
    total = 1 + nbits;
    if (par != 0) begin
      bits[total] = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      total++;
    end
    total += stops;
    applyStimulus(d, 1'b1, data);
    if (d == 0) exp_q.push_back(data);
    @(negedge clk);
    applyStimulus(d, 1'b0, data);
    checkOutput("lat_tx", tx_v[d], 1);
    checkOutput("lat_empty", empty_v[d], 0);
    checkOutput("lat_busy", busy_v[d], 0);
    for (int c = 0; c < total * clks; c++) begin
      @(negedge clk);
      checkOutput("frame_tx", tx_v[d], bits[c / clks]);
      checkOutput("frame_done", done_v[d], c == total * clks - 1);
      checkOutput("frame_busy", busy_v[d], 1);
    end
    @(negedge clk);
    checkOutput("end_tx", tx_v[d], 1);
    checkOutput("end_busy", busy_v[d], 0);
    checkOutput("end_state", st_v[d], 0);
    checkOutput("end_done", done_v[d], 0);
  endtask

  // Frame decoder on dut_a's line: mid-bit sampling, done pulse position and idle gaps.
  initial begin
    forever begin
      @(negedge clk);
      if (!rx_en) begin
        rx_active = 0;
      end else begin
        if (!rx_active && tx_v[0] == 1'b0) begin
          rx_active = 1;
          rx_cnt    = 0;
        end
        if (rx_active) begin
          if (rx_cnt % A_CLKS == A_CLKS / 2) rx_bits[rx_cnt / A_CLKS] = tx_v[0];
          checkOutput("rx_done", done_v[0], rx_cnt == A_FRAME_CYC - 1);
          if (rx_cnt == A_FRAME_CYC - 1) begin
            rx_active = 0;
            checkOutput("rx_start", rx_bits[0], 0);
            checkOutput("rx_stop", rx_bits[10], 1);
            checkOutput("rx_queue", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              rx_b = exp_q.pop_front();
              checkOutput("rx_data", rx_bits[8:1], rx_b);
              checkOutput("rx_parity", rx_bits[9], ^rx_b);
            end
          end else begin
            rx_cnt++;
          end
        end else begin
          if (exp_q.size() > 0) gap_cnt++;
          checkOutput("rx_idle_done", done_v[0], 0);
        end
      end
    end
  end

  initial begin
    int w;
    vectors     = 0;
    miscompares = 0;
    rx_en       = 0;
    rx_active   = 0;
    rx_cnt      = 0;
    gap_cnt     = 0;
    rx_bits     = '0;
    rx_b        = '0;
    data_a      = '0;
    data_b      = '0;
    data_c      = '0;
    for (int d = 0; d < 3; d++) send_v[d] = 1'b0;

    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[2] = '{1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[3] = '{1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[4] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1};
    vecs[5] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_tx", tx_v[d], 1);
      checkOutput("rst_busy", busy_v[d], 0);
      checkOutput("rst_full", full_v[d], 0);
      checkOutput("rst_empty", empty_v[d], 1);
      checkOutput("rst_ovf", ovf_v[d], 0);
      checkOutput("rst_done", done_v[d], 0);
      checkOutput("rst_state", st_v[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    rx_en = 1;

    $display("[TB] exact frames");
    checkExactFrame(0, 8'hA5, 8, 1, 1, 4);
    checkExactFrame(0, 8'h01, 8, 1, 1, 4);
    checkExactFrame(1, 8'h00, 8, 2, 1, 4);
    checkExactFrame(2, 8'h55, 7, 0, 2, 3);

    $display("[TB] push table with overflow");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, vecs[i].send, vecs[i].data);
      if (vecs[i].accept) exp_q.push_back(vecs[i].data);
      @(negedge clk);
      checkOutput("tbl_empty", empty_v[0], vecs[i].e_empty);
      checkOutput("tbl_full", full_v[0], vecs[i].e_full);
      checkOutput("tbl_ovf", ovf_v[0], vecs[i].e_ovf);
      checkOutput("tbl_busy", busy_v[0], vecs[i].e_busy);
      checkOutput("tbl_state", st_v[0], vecs[i].e_state);
    end
    gap_cnt = 0;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    checkOutput("tbl_drain", exp_q.size(), 0);
    checkOutput("tbl_gap", gap_cnt, 0);
    @(negedge clk);
    checkOutput("tbl_idle_busy", busy_v[0], 0);
    checkOutput("tbl_idle_tx", tx_v[0], 1);
    checkOutput("tbl_idle_empty", empty_v[0], 1);

    $display("[TB] reset mid-frame");
    rx_en = 0;
    exp_q.delete();
    applyStimulus(0, 1'b1, 8'h5A);
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'hC3);
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'h99);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00);
    w = 0;
    while (st_v[0] != 3'd2 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("mid_reach_data", st_v[0], 2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_tx", tx_v[0], 1);
    checkOutput("mid_empty", empty_v[0], 1);
    checkOutput("mid_full", full_v[0], 0);
    checkOutput("mid_busy", busy_v[0], 0);
    checkOutput("mid_state", st_v[0], 0);
    checkOutput("mid_done", done_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("post_tx", tx_v[0], 1);
      checkOutput("post_done", done_v[0], 0);
      checkOutput("post_empty", empty_v[0], 1);
      checkOutput("post_busy", busy_v[0], 0);
    end
    rx_en = 1;

    $display("[TB] random traffic");
    for (int n = 0; n < 24; n++) begin
      int         gapn;
      logic [7:0] b;
      gapn = $urandom_range(0, 50);
      repeat (gapn) @(negedge clk);
      for (int k = 0; k < 200 && full_v[0]; k++) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      applyStimulus(0, 1'b1, b);
      exp_q.push_back(b);
      @(negedge clk);
      applyStimulus(0, 1'b0, 8'h00);
    end
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rand_drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    checkOutput("rand_idle_busy", busy_v[0], 0);
    checkOutput("rand_idle_tx", tx_v[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format and compile-time baud divisor. It sits between the bus-side peripheral register block (which pushes bytes) and the `tx` pad. It is the generalised successor of the fixed 8E1, single-buffer transmitter, and sends back-to-back frames with no idle gap while the FIFO holds data.

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 1: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: reset, asynchronous and active-high.
- `tx_send`, in, 1: push strobe; one entry per cycle high.
- `tx_data`, in, DATA_BITS: data sampled when `tx_send`=1.
- `tx`, out, 1: serial line; registered; idles high.
- `busy`, out, 1: high whenever the FSM is not IDLE.
- `fifo_full`, out, 1: FIFO holds FIFO_DEPTH entries.
- `fifo_empty`, out, 1: FIFO holds 0 entries.
- `tx_overflow`, out, 1: one-cycle pulse when a push is rejected.
- `tx_done`, out, 1: one-cycle pulse at the end of each frame's last stop bit.
- `tx_state`, out, 3: FSM state; IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_empty`=1, `tx_overflow`=0, `tx_done`=0, `tx_state`=0. Reset also clears the FIFO pointers and count, the baud counter and the bit counter.
- Push: `tx_send`=1 and not full writes `tx_data` at the tail.
  - Push while full is dropped and pulses `tx_overflow`, even if a pop occurs in the same cycle; the full flag is evaluated before the pop.
  - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head into the shift register, reset the baud and bit counters, and go to START.
  - START: `tx`=0 for one bit time, then go to DATA.
  - DATA: send DATA_BITS bits LSB first, one bit time each. After the last bit go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: send the parity bit. Even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: `tx`=1 for STOP_BITS bit times. At the end, pulse `tx_done`. If the FIFO is not empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit ends on the cycle the counter equals CLKS_PER_BIT-1.
- Bit counter width is clog2(DATA_BITS+1); it wraps only through reset on state entry.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exact, with no jitter.
- Async reset mid-frame: `tx` returns to 1 immediately, the frame is aborted, queued data is discarded, and no `tx_done` is issued.

## Timing
- A push into an empty FIFO while IDLE is sampled at edge N: `fifo_empty` falls after edge N. The FSM pops at edge N+1, and `tx` falls after edge N+1 (latency 2 cycles).
- Every bit, including the start and each stop bit, holds `tx` for exactly CLKS_PER_BIT cycles.
- `tx_done` is high during the final cycle of the last stop bit. The next frame's start bit, if any, begins on the following cycle.
- `busy` rises with the START entry and falls on entry to IDLE.
- `fifo_full`, `fifo_empty` and `tx_state` are registered and update on the edge after the causing event.

## Test plan
- Defaults with CLKS_PER_BIT=4; push 0xA5 → `tx` sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 4 cycles. `tx_done` pulses 44 cycles after the start bit begins, then `busy`=0.
- PARITY=2, push 0x00 → parity bit 1; PARITY=1, push 0x01 → parity bit 1.
- FIFO_DEPTH=4; push 6 bytes on consecutive cycles → 5 accepted, `tx_overflow` pulses on the 6th. Then 5 contiguous frames, with no idle high between the stop bit and the next start bit, in push order.
- DATA_BITS=7, PARITY=0, STOP_BITS=2, CLKS_PER_BIT=3; push 0x55 → 10-bit frame of 30 cycles; both stop bits high for 6 cycles total.
- Assert `rst` mid-DATA with 2 bytes queued → `tx`=1, `fifo_empty`=1, `busy`=0, `tx_state`=0 immediately; no `tx_done`. After release, line idle until the next push.
